// File: rtl/arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
package arith_pkg;

    localparam int unsigned SERIAL_W_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Bit-counter width for an n-bit serial operation.
    function automatic int unsigned cnt_w(input int unsigned n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor: the borrow-chain dual of the full-adder cell.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    logic w_axb;

    assign w_axb = a ^ b;
    assign diff  = w_axb ^ bin;
    assign bout  = (~a & b) | (~w_axb & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit unsigned subtractor, LSB first, with valid/ready handshakes
// on both the operand and result sides.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int unsigned N = SERIAL_W_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] diff,
    output logic         borrow
);

    localparam int unsigned CW = cnt_w(N);

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [N-1:0]    r_a;
    logic [N-1:0]    r_b;
    logic [N-2:0]    r_res;
    logic            r_bin;
    logic            r_in_ready;
    logic            r_out_valid;
    logic [N-1:0]    r_diff;
    logic            r_borrow;

    logic            w_d;
    logic            w_bout;
    logic [N-1:0]    w_res_next;

    full_subtractor u_fs (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .bin  (r_bin),
        .diff (w_d),
        .bout (w_bout)
    );

    // Result bits enter from the MSB side; the final shift completes the word.
    assign w_res_next = {w_d, r_res};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_res       <= '0;
            r_bin       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_diff      <= '0;
            r_borrow    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a        <= a;
                        r_b        <= b;
                        r_bin      <= 1'b0;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_res <= w_res_next[N-1:1];
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_bin <= w_bout;
                    r_cnt <= r_cnt + CW'(1);
                    // Outputs update only here, so they stay stable through DONE.
                    if (r_cnt == CW'(N - 1)) begin
                        r_diff      <= w_res_next;
                        r_borrow    <= w_bout;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign diff      = r_diff;
    assign borrow    = r_borrow;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at N=4 and N=8 against an
// arithmetic reference model.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       reset;
    logic       iv;
    logic       ordy;
    logic       sel;
    logic [7:0] a;
    logic [7:0] b;

    logic       in_valid4, out_ready4, in_ready4, out_valid4, borrow4;
    logic [3:0] diff4;
    logic       in_valid8, out_ready8, in_ready8, out_valid8, borrow8;
    logic [7:0] diff8;

    logic       cur_in_ready, cur_out_valid, cur_borrow;
    logic [7:0] cur_diff;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign in_valid4  = iv & ~sel;
    assign out_ready4 = ordy & ~sel;
    assign in_valid8  = iv & sel;
    assign out_ready8 = ordy & sel;

    always_comb begin
        cur_in_ready  = sel ? in_ready8  : in_ready4;
        cur_out_valid = sel ? out_valid8 : out_valid4;
        cur_borrow    = sel ? borrow8    : borrow4;
        cur_diff      = sel ? diff8      : {4'b0, diff4};
    end

    serial_subtractor #(.N(4)) u_dut4 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .a         (a[3:0]),
        .b         (b[3:0]),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .diff      (diff4),
        .borrow    (borrow4)
    );

    serial_subtractor #(.N(8)) u_dut8 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .a         (a),
        .b         (b),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .diff      (diff8),
        .borrow    (borrow8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: (x - y) mod 2^n using plain integer arithmetic.
    function automatic logic [7:0] ref_diff(input int n, input int x, input int y);
        return 8'((x - y + (1 << n)) % (1 << n));
    endfunction

    // One operation through the currently selected DUT.
    task automatic run_op(input string tag, input int n, input logic [7:0] ta,
                          input logic [7:0] tb_v, input int hold, input bit toggle);
        int         lat;
        int         waitc;
        logic [7:0] ed;
        logic       eb;
        logic [8:0] s;
        int         mask;
        mask = (1 << n) - 1;
        ed   = ref_diff(n, int'(ta), int'(tb_v));
        eb   = (ta < tb_v);
        waitc = 0;
        while (!cur_in_ready && waitc < 50) begin
            @(posedge clk); #1;
            waitc++;
        end
        check({tag, "_rdy"}, 32'(cur_in_ready), 32'd1);
        a  = ta;
        b  = tb_v;
        iv = 1'b1;
        @(posedge clk); #1;
        iv  = 1'b0;
        lat = 0;
        do begin
            if (toggle) begin
                iv = 1'($urandom);
                a  = 8'($urandom);
                b  = 8'($urandom);
            end
            @(posedge clk); #1;
            lat++;
        end while (!cur_out_valid && lat < 50);
        check({tag, "_lat"}, 32'(lat), 32'(n));
        check({tag, "_diff"}, 32'(cur_diff), 32'(ed));
        check({tag, "_borrow"}, 32'(cur_borrow), 32'(eb));
        check({tag, "_busy"}, 32'(cur_in_ready), 32'd0);
        s = 9'(cur_diff) + 9'(tb_v);
        check({tag, "_addsum"}, 32'(int'(s) & mask), 32'(ta));
        check({tag, "_addcarry"}, 32'(s[n]), 32'(eb));
        for (int i = 0; i < hold; i++) begin
            if (toggle) begin
                iv = 1'($urandom);
                a  = 8'($urandom);
                b  = 8'($urandom);
            end
            @(posedge clk); #1;
            check({tag, "_hold_v"}, 32'(cur_out_valid), 32'd1);
            check({tag, "_hold_d"}, 32'(cur_diff), 32'(ed));
            check({tag, "_hold_b"}, 32'(cur_borrow), 32'(eb));
            check({tag, "_hold_rdy"}, 32'(cur_in_ready), 32'd0);
        end
        iv   = 1'b0;
        ordy = 1'b1;
        @(posedge clk); #1;
        ordy = 1'b0;
        check({tag, "_drop_v"}, 32'(cur_out_valid), 32'd0);
        check({tag, "_idle_rdy"}, 32'(cur_in_ready), 32'd1);
    endtask

    // Back-to-back operations with in_valid and out_ready held high.
    task automatic run_stream(input int n, input int count);
        logic [7:0] qa[$];
        logic [7:0] qb[$];
        logic [7:0] ea, eb;
        logic [8:0] s;
        int         got, cyc, last, mask;
        got  = 0;
        cyc  = 0;
        last = -1;
        mask = (1 << n) - 1;
        a    = 8'($urandom) & 8'(mask);
        b    = 8'($urandom) & 8'(mask);
        iv   = 1'b1;
        ordy = 1'b1;
        while (got < count && cyc < count * (n + 2) + 100) begin
            @(negedge clk);
            cyc++;
            if (cur_out_valid) begin
                if (qa.size() == 0) begin
                    check("stream_spurious", 32'd1, 32'd0);
                end else begin
                    ea = qa.pop_front();
                    eb = qb.pop_front();
                    check("stream_diff", 32'(cur_diff), 32'(ref_diff(n, int'(ea), int'(eb))));
                    check("stream_borrow", 32'(cur_borrow), 32'(ea < eb));
                    s = 9'(cur_diff) + 9'(eb);
                    check("stream_addsum", 32'(int'(s) & mask), 32'(ea));
                    check("stream_addcarry", 32'(s[n]), 32'(ea < eb));
                end
                if (last >= 0) check("stream_ii", 32'(cyc - last), 32'(n + 2));
                last = cyc;
                got++;
            end
            if (cur_in_ready) begin
                qa.push_back(a);
                qb.push_back(b);
            end
            @(posedge clk); #1;
            a = 8'($urandom) & 8'(mask);
            b = 8'($urandom) & 8'(mask);
        end
        check("stream_count", 32'(got), 32'(count));
        iv = 1'b0;
        repeat (n + 4) @(posedge clk);
        #1;
        ordy = 1'b0;
    endtask

    initial begin
        int seen;
        reset = 1'b1;
        iv    = 1'b0;
        ordy  = 1'b0;
        sel   = 1'b0;
        a     = '0;
        b     = '0;
        #1;
        check("rst_rdy4", 32'(in_ready4), 32'd1);
        check("rst_ov4", 32'(out_valid4), 32'd0);
        check("rst_diff4", 32'(diff4), 32'd0);
        check("rst_borrow4", 32'(borrow4), 32'd0);
        check("rst_rdy8", 32'(in_ready8), 32'd1);
        check("rst_ov8", 32'(out_valid8), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        run_op("a9b3", 4, 8'd9, 8'd3, 0, 1'b0);
        run_op("a3b9", 4, 8'd3, 8'd9, 0, 1'b0);
        run_op("aFbF", 4, 8'd15, 8'd15, 0, 1'b0);
        run_op("a0b1", 4, 8'd0, 8'd1, 0, 1'b0);
        run_op("bp", 4, 8'd12, 8'd5, 5, 1'b1);

        // Abort during the second bit cycle; reset acts without a clock edge.
        a  = 8'd12;
        b  = 8'd3;
        iv = 1'b1;
        @(posedge clk); #1;
        iv = 1'b0;
        @(posedge clk); #1;
        #2 reset = 1'b1;
        #1;
        check("abort_rdy", 32'(in_ready4), 32'd1);
        check("abort_ov", 32'(out_valid4), 32'd0);
        check("abort_diff", 32'(diff4), 32'd0);
        #1 reset = 1'b0;
        seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid4) seen = 1;
        end
        check("abort_no_ov", 32'(seen), 32'd0);
        run_op("a5b7", 4, 8'd5, 8'd7, 0, 1'b0);

        run_stream(4, 1000);

        sel = 1'b1;
        @(posedge clk); #1;
        run_op("w8", 8, 8'd200, 8'd37, 0, 1'b0);
        run_op("w8neg", 8, 8'd1, 8'd255, 2, 1'b1);
        run_stream(8, 1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial N-bit unsigned subtractor for the FIR datapath. It computes (a − b) mod 2^N and a borrow flag, one bit per clock, LSB first, through a single full-subtractor cell. It is the inverse companion to the ripple-carry adder and trades latency for area. Operands enter and results leave over valid/ready handshakes, so the block can sit between pipeline stages without extra glue.

## Interface
- `N`, default 4: operand and result width; legal range N ≥ 2.

- `clk`  input  1  single clock; all state changes on its rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `in_valid`  input  1  operand pair on `a`/`b` is valid.
- `in_ready`  output  1  block accepts operands; high only in IDLE.
- `a`  input  N  minuend, unsigned.
- `b`  input  N  subtrahend, unsigned.
- `out_valid`  output  1  `diff`/`borrow` hold a completed result.
- `out_ready`  input  1  consumer takes the result.
- `diff`  output  N  (a − b) mod 2^N.
- `borrow`  output  1  1 iff a < b (unsigned).

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`: capture `a`→A shift register and `b`→B shift register, clear the borrow flop and the bit counter, go to SHIFT.
- SHIFT, each cycle:
  - Cell inputs: a0=A[0], b0=B[0], bin=borrow flop.
  - d = a0^b0^bin.
  - bout = (~a0&b0) | (~(a0^b0)&bin).
  - Shift d into the result register from the MSB side.
  - Shift A and B right by one; borrow flop ← bout; counter++.
  - After the cycle with counter==N−1, go to DONE.
- DONE:
  - `out_valid`=1; `diff` = result register; `borrow` = borrow flop.
  - On `out_ready`: go to IDLE.
- Arithmetic invariant: diff + b = a + borrow·2^N, exactly. Adding `diff` and `b` in the adder returns `a`, with carry equal to `borrow`.
- Boundary conditions:
  - `in_valid` outside IDLE is ignored; operands are not sampled.
  - `a`/`b` may change freely after the accepting edge.
  - While `out_valid`=1 and `out_ready`=0, `diff` and `borrow` hold stable.
  - `out_ready` asserted outside DONE has no effect.
  - A new accept is not permitted in the same cycle as the DONE→IDLE transition.
  - Reset asserted in any state aborts the operation. The partial result is discarded and no `out_valid` pulse occurs.

## Timing
- Reset values (applied asynchronously):
  - state=IDLE, `in_ready`=1.
  - `out_valid`=0, `diff`=0, `borrow`=0.
  - Counter, A and B cleared.
- `in_ready` and `out_valid` are decoded directly from state registers, with no combinational path from `in_valid` or `out_ready`.
- Latency: operands accepted on edge T → `out_valid` high from edge T+N.
- With `out_ready` held high, DONE lasts one cycle.
- Minimum initiation interval is N+2 cycles per operation.
- `diff`/`borrow` change only on the final SHIFT edge and on reset.

## Structure
- Shared package `arith_pkg`:
  - state enum {IDLE, SHIFT, DONE};
  - counter width constant, computed as $clog2(N);
  - reused by later serial arithmetic blocks.
- One sub-module, `full_subtractor` (a, b, bin → diff, bout), instantiated once. It is the borrow-chain dual of the adder's full-adder cell.
- Top level holds the FSM, counter, A/B/result shift registers and the borrow flop.

## Test plan
- N=4, a=9, b=3 → `diff`=6, `borrow`=0; `out_valid` rises exactly 4 edges after accept.
- a=3, b=9 → `diff`=0xA, `borrow`=1. a=0, b=1 → `diff`=0xF, `borrow`=1. a=b=0xF → `diff`=0, `borrow`=0.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE → `out_valid`, `diff` and `borrow` remain stable. Toggling `in_valid` and `a`/`b` during SHIFT/DONE leaves the result unchanged and `in_ready`=0.
- Reset asserted mid-SHIFT (second bit cycle) → `in_ready`=1 and `out_valid`=0 immediately without a clock edge. The next operation, a=5, b=7, yields `diff`=0xE, `borrow`=1.
- Streaming with `in_valid` and `out_ready` held high:
  - one result every N+2 cycles;
  - 1000 random pairs at N=4 and N=8 checked against a reference model;
  - each result also checked through the adder: sum==a and carry==`borrow`.
